// File: rtl/fx_mul_pkg.sv
// Shared types and defaults for the fixed-point multiplier scheduler.
// Tag width is derived from the requester count.
package fx_mul_pkg;

    localparam int MUL_LAT_DEFAULT = 4;
    localparam int N_REQ_DEFAULT   = 4;

    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_w(N_REQ_DEFAULT);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } mul_tag_t;

endpackage

// File: rtl/fx_mul_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant on the first eligible index after
// the pointer; the pointer moves only when the grant is accepted.
module rr_arbiter
    import fx_mul_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = id_w(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] elig,
    input  logic             accept,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    gnt_id
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant  = '0;
        gnt_id = ptr_q;
        sum    = '0;
        idx    = '0;
        found  = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            sum = {1'b0, ptr_q} + off[IW:0];
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            idx = sum[IW-1:0];
            if (!found && elig[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = gnt_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IW'(N_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fx_mul_sched.sv
// Shares one pipelined fixed-point multiplier among N_REQ requesters and
// steers each product back using a tag pipe matched to the multiplier latency.
module fx_mul_sched
    import fx_mul_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int MAX_OUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic                   hold,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic [WIDTH-1:0]       mul_result,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   idle
);

    localparam int IW = id_w(N_REQ);
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] id;
    } tag_t;

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gid;
    logic             acc;

    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [CW-1:0]    cnt_q [N_REQ];
    logic [CW-1:0]    cnt_d [N_REQ];
    tag_t             tag_q [MUL_LAT+1];
    tag_t             tag_d [MUL_LAT+1];
    tag_t             last;
    logic             busy;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] & ~hold
                    & (cnt_q[i] < CW'(MAX_OUT));
        end
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .elig   (elig),
        .accept (acc),
        .grant  (gnt),
        .gnt_id (gid)
    );

    // Grants go only to valid requesters, so any grant is a handshake.
    assign acc = |gnt;

    always_comb begin
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                mul_a_d = req_a[i*WIDTH +: WIDTH];
                mul_b_d = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        tag_d[0].vld = acc;
        tag_d[0].id  = gid;
        for (int j = 1; j <= MUL_LAT; j++) begin
            tag_d[j] = tag_q[j-1];
        end
    end

    always_comb begin
        last         = tag_q[MUL_LAT];
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        if (last.vld) begin
            rsp_valid_d[last.id] = 1'b1;
            rsp_result_d         = mul_result;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            unique case ({gnt[i], rsp_valid_q[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_comb begin
        busy = |rsp_valid_q;
        for (int j = 0; j <= MUL_LAT; j++) begin
            busy = busy | tag_q[j].vld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            for (int j = 0; j <= MUL_LAT; j++) begin
                tag_q[j] <= '0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            for (int j = 0; j <= MUL_LAT; j++) begin
                tag_q[j] <= tag_d[j];
            end
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign req_ready  = gnt;
    assign mul_start  = tag_q[0].vld;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign idle       = ~busy;

endmodule

// File: tb/tb_fx_mul_sched.sv
// Directed and random bench for fx_mul_sched with a Q16.16 multiplier model
// of latency 4 and a scoreboard of accepted ops.
module tb_fx_mul_sched;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int LAT = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           hold = 1'b0;
    logic           mul_start;
    logic [W-1:0]   mul_a, mul_b, mul_result;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_result;
    logic           idle;

    fx_mul_sched #(
        .WIDTH(W), .N_REQ(N), .MUL_LAT(LAT), .MAX_OUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .hold(hold),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .idle(idle)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] q16mul(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic signed [63:0] p;
        p = $signed(a) * $signed(b);
        return p[47:16];
    endfunction

    // Multiplier model: product appears LAT cycles after mul_start.
    logic [W-1:0] mpipe [1:LAT];
    always @(posedge clk) begin
        mpipe[1] <= q16mul(mul_a, mul_b);
        for (int j = 2; j <= LAT; j++) mpipe[j] <= mpipe[j-1];
    end
    assign mul_result = mpipe[LAT];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           id;
        logic [W-1:0] res;
        int           c;
    } ent_t;
    ent_t sb[$];
    int   outs [N];

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            for (int i = 0; i < N; i++) outs[i] = 0;
        end else begin
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("rsp_id", rsp_valid, 64'(1) << e.id);
                    chk("rsp_val", rsp_result, e.res);
                    chk("rsp_lat", cyc - e.c, 6);
                    outs[e.id]--;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    ent_t e;
                    e.id  = i;
                    e.res = q16mul(req_a[i*W +: W], req_b[i*W +: W]);
                    e.c   = cyc;
                    sb.push_back(e);
                    outs[i]++;
                    chk("max_out", outs[i] <= 4, 1);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (!idle && n < 30) begin
            tick();
            n++;
        end
        chk("drain_idle", idle, 1);
    endtask

    task automatic single_op(input int id, input logic [W-1:0] a,
                             input logic [W-1:0] b,
                             input logic [W-1:0] exp);
        int n;
        tick();
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid = N'(1) << id;
        #1;
        chk("op_ready", req_ready, 64'(1) << id);
        tick();
        req_valid = '0;
        #1;
        chk("op_start", mul_start, 1);
        chk("op_mul_a", mul_a, a);
        chk("op_mul_b", mul_b, b);
        n = 1;
        while (rsp_valid == '0 && n < 20) begin
            tick();
            n++;
        end
        chk("op_lat", n, 6);
        chk("op_rsp_id", rsp_valid, 64'(1) << id);
        chk("op_rsp_val", rsp_result, exp);
        tick();
        chk("op_idle", idle, 1);
    endtask

    int  nxt;
    bit  pat3 [14] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    logic [N-1:0] seen;
    logic [N-1:0] prev;

    initial begin
        tick();
        tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_start", mul_start, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_rsp_v", rsp_valid, 0);
        chk("rst_rsp_r", rsp_result, 0);
        chk("rst_idle", idle, 1);
        rst = 1'b0;

        single_op(0, 32'h0002_0000, 32'h0003_0000, 32'h0006_0000);

        req_a = {32'h0003_0000, 32'h0000_4000,
                 32'hFFFE_0000, 32'h0001_8000};
        req_b = {32'hFFFF_8000, 32'h0010_0000,
                 32'h0002_8000, 32'h0002_0000};
        nxt = 1;
        for (int c = 0; c < 12; c++) begin
            tick();
            req_valid = '1;
            #1;
            chk("rr_grant", req_ready, 64'(1) << nxt);
            if (c > 0) chk("rr_start", mul_start, 1);
            nxt = (nxt + 1) % N;
        end
        tick();
        req_valid = '0;
        wait_idle();

        for (int c = 0; c < 14; c++) begin
            tick();
            req_valid = 4'b0100;
            #1;
            chk("req2_ready", req_ready[2], pat3[c]);
        end
        tick();
        req_valid = '0;
        wait_idle();

        nxt = 3;
        for (int c = 0; c < 6; c++) begin
            tick();
            req_valid = '1;
            #1;
            chk("pre_hold_grant", req_ready, 64'(1) << nxt);
            nxt = (nxt + 1) % N;
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            hold = 1'b1;
            #1;
            chk("hold_ready", req_ready, 0);
            if (c > 0) chk("hold_start", mul_start, 0);
        end
        prev = '0;
        for (int n = 0; n < 20 && !idle; n++) begin
            prev = rsp_valid;
            tick();
        end
        chk("hold_idle", idle, 1);
        chk("idle_after_rsp", prev != '0, 1);
        tick();
        hold = 1'b0;
        #1;
        chk("resume_grant", req_ready, 64'(1) << nxt);
        tick();
        req_valid = '0;
        wait_idle();

        for (int c = 0; c < 5; c++) begin
            tick();
            req_valid = '1;
        end
        tick();
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("mid_rst_idle", idle, 1);
        chk("mid_rst_start", mul_start, 0);
        tick();
        rst = 1'b0;
        seen = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            seen = seen | rsp_valid;
        end
        chk("rst_no_rsp", seen, 0);
        chk("rst_after_idle", idle, 1);
        single_op(1, 32'hFFFF_0000, 32'h0002_8000, 32'hFFFD_8000);

        for (int c = 0; c < 3000; c++) begin
            tick();
            req_valid = N'($urandom);
            hold = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = $urandom;
                req_b[i*W +: W] = $urandom;
            end
        end
        tick();
        req_valid = '0;
        hold = 1'b0;
        wait_idle();
        tick();
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
